mux_sampler: RTL
================

MUX_SAMPLER -- requirements
Module: mux_sampler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clock CLK, reset RST_L, sampled only on the CLK rising edge.
REQ-002 The block SHALL have parameter SETTLE, default 1, range 0-15: the number of extra wait cycles after each select change before Y is captured.
REQ-003 The block SHALL have ports CLK, input, 1 bit: system clock.
REQ-004 The block SHALL have port RST_L, input, 1 bit: synchronous active-low reset.
REQ-005 The block SHALL have port START, input, 1 bit: request one A/B capture transaction.
REQ-006 The block SHALL have port Y[3:0], input, 4 bits: data returned by the downstream quad 2:1 mux.
REQ-007 The block SHALL have port E_L, output, 1 bit: active-low mux enable.
REQ-008 The block SHALL have port S, output, 1 bit: mux select, where 0 selects the A nibble and 1 selects the B nibble.
REQ-009 The block SHALL have port QA[3:0], output, 4 bits: the captured A nibble.
REQ-010 The block SHALL have port QB[3:0], output, 4 bits: the captured B nibble.
REQ-011 The block SHALL have port BUSY, output, 1 bit: high while a transaction is in progress.
REQ-012 The block SHALL have port DONE, output, 1 bit: a one-cycle pulse when a transaction completes.
REQ-013 The block SHALL have port EQ, output, 1 bit: registered result of QA==QB, updated together with DONE.

Function
REQ-014 The FSM SHALL have the states IDLE, SEL_A, SEL_B and FIN, all fully registered.
REQ-015 In IDLE, the outputs SHALL be E_L=1, S=0, BUSY=0 and DONE=0.
REQ-016 In IDLE, START=1 at a rising edge SHALL move the FSM to SEL_A and load the wait counter with SETTLE.
REQ-017 In SEL_A, the outputs SHALL be E_L=0, S=0 and BUSY=1.
REQ-018 In SEL_A, the counter SHALL decrement each cycle while it is nonzero.
REQ-019 In SEL_A, at the edge where the counter equals 0: QA<=Y, state->SEL_B, and the counter reloads SETTLE.
REQ-020 In SEL_B, the outputs SHALL be E_L=0, S=1 and BUSY=1, with the same counting rule as SEL_A.
REQ-021 In SEL_B, at the edge where the counter equals 0: QB<=Y, EQ<=(QA==Y), state->FIN.
REQ-022 In FIN, the outputs SHALL be DONE=1, E_L=1, S=0 and BUSY=0 for exactly one cycle, followed by an unconditional return to IDLE.
REQ-023 Latency: DONE SHALL be observed high after the (2*SETTLE+2)th rising edge following the edge that sampled START.
REQ-024 With SETTLE=0, SEL_A and SEL_B SHALL each last exactly one cycle.
REQ-025 START SHALL be ignored in SEL_A, SEL_B and FIN, and no request is queued; START held high continuously SHALL start back-to-back transactions with one IDLE cycle between them.
REQ-026 QA, QB and EQ SHALL hold their values until overwritten by the next capture; Y changes outside a capture edge SHALL have no effect.
REQ-027 All outputs SHALL be driven from registers, with no combinational path from START or Y to any output.

Reset
REQ-028 RST_L=0 at a rising edge SHALL force IDLE, counter=0, QA=0, QB=0, EQ=0, DONE=0, BUSY=0, E_L=1 and S=0, from any state.
REQ-029 A reset during SEL_A or SEL_B SHALL abort the transaction: no DONE pulse, and the partial capture is cleared.
REQ-030 START asserted on the same edge as RST_L=0 SHALL be ignored.

Configuration
REQ-031 Macro MUX_SAMPLER_CNT_EN defined: the block SHALL add output CNT[7:0], a count of completed transactions that increments on entry to FIN, wraps 255->0, and resets to 0.
REQ-032 Macro MUX_SAMPLER_CNT_EN undefined: the CNT port and its logic SHALL be absent, and all other behaviour is identical.

Verification
All scenarios SHALL use the bench mux model Y = E_L ? 0 : (S ? B : A), with A=4'b1010 and B=4'b0101 unless stated.
REQ-033 Reset, then one START pulse with SETTLE=1 -> BUSY high for 4 cycles, then DONE pulses once with QA=1010, QB=0101, EQ=0, and E_L=1 after completion.
REQ-034 A=B=4'b0110, SETTLE=0, START pulse -> DONE 2 edges after the START edge, with QA=QB=0110 and EQ=1.
REQ-035 A second START pulse while BUSY=1 -> ignored; exactly one DONE pulse occurs and QA/QB are unchanged by the second pulse.
REQ-036 RST_L=0 for one cycle during SEL_B -> next cycle shows IDLE outputs, QA=0, no DONE pulse; a following START completes normally.
REQ-037 START held high for 3 transactions with SETTLE=2 -> DONE pulses are spaced 8 cycles apart; with MUX_SAMPLER_CNT_EN defined, CNT=3 afterwards.
REQ-038 With MUX_SAMPLER_CNT_EN defined, run 256 transactions -> CNT wraps to 0.

Source files
------------

// File: rtl/mux_sampler.sv
// Sequences a downstream quad 2:1 mux to capture the A and B nibbles, then flags QA==QB.
// Optional MUX_SAMPLER_CNT_EN adds a CNT output counting completed transactions.
module mux_sampler #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       CLK,
  input  logic       RST_L,
  input  logic       START,
  input  logic [3:0] Y,
  output logic       E_L,
  output logic       S,
  output logic [3:0] QA,
  output logic [3:0] QB,
  output logic       BUSY,
  output logic       DONE,
  output logic       EQ
`ifdef MUX_SAMPLER_CNT_EN
  ,
  output logic [7:0] CNT
`endif
);

  localparam logic [3:0] SettleLd = 4'(SETTLE);

  typedef enum logic [1:0] {
    StIdle,
    StSelA,
    StSelB,
    StFin
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [3:0] qa_q, qa_d;
  logic [3:0] qb_q, qb_d;
  logic       eq_q, eq_d;
  logic       e_l_q, e_l_d;
  logic       s_q, s_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    qa_d    = qa_q;
    qb_d    = qb_q;
    eq_d    = eq_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d = StSelA;
          wait_d  = SettleLd;
        end
      end
      StSelA: begin
        if (wait_q == 4'd0) begin
          qa_d    = Y;
          state_d = StSelB;
          wait_d  = SettleLd;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StSelB: begin
        if (wait_q == 4'd0) begin
          qb_d    = Y;
          eq_d    = (qa_q == Y);
          state_d = StFin;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    e_l_d  = 1'b1;
    s_d    = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      StSelA: begin
        e_l_d  = 1'b0;
        busy_d = 1'b1;
      end
      StSelB: begin
        e_l_d  = 1'b0;
        s_d    = 1'b1;
        busy_d = 1'b1;
      end
      StFin: begin
        done_d = 1'b1;
      end
      default: begin
        e_l_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_L) begin
      state_q <= StIdle;
      wait_q  <= 4'd0;
      qa_q    <= 4'd0;
      qb_q    <= 4'd0;
      eq_q    <= 1'b0;
      e_l_q   <= 1'b1;
      s_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      qa_q    <= qa_d;
      qb_q    <= qb_d;
      eq_q    <= eq_d;
      e_l_q   <= e_l_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign E_L  = e_l_q;
  assign S    = s_q;
  assign QA   = qa_q;
  assign QB   = qb_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign EQ   = eq_q;

`ifdef MUX_SAMPLER_CNT_EN
  logic [7:0] tx_cnt_q, tx_cnt_d;
  logic       fin_entry;

  assign fin_entry = (state_d == StFin) && (state_q != StFin);

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (fin_entry) begin
      tx_cnt_d = tx_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_L) begin
      tx_cnt_q <= 8'd0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
    end
  end

  assign CNT = tx_cnt_q;
`endif

endmodule
